// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding Wishbone B4 classic initiator.
// It turns one valid/ready command into one bus cycle and returns a single
// response on a valid/ready channel.
//
// Build option: define WB_MASTER_PORT_TIMEOUT_EN to compile in the watchdog.
// With the watchdog, a bus cycle that gets no ack_i or err_i within
// TIMEOUT_CYCLES cycles ends with rsp_err=1 and rsp_timeout=1. Without it,
// BUS waits indefinitely and rsp_timeout is tied to 0.
//
// Ports:
//   clk_i, rst_i                        clock; async active-high reset
//   cmd_valid/ready/we/adr/dat/sel      command channel
//   rsp_valid/ready/dat/err/timeout     response channel
//   busy                                high whenever the FSM is not in IDLE
//   adr_o/dat_o/sel_o/we_o/cyc_o/stb_o  Wishbone request
//   dat_i/ack_i/err_i                   Wishbone response
module wb_master_port #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr,
   input  logic [WIDTH-1:0]        cmd_dat,
   input  logic [WIDTH/8-1:0]      cmd_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [WIDTH-1:0]        rsp_dat,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [WIDTH-1:0]        dat_o,
   output logic [WIDTH/8-1:0]      sel_o,
   output logic                    we_o,
   output logic                    cyc_o,
   output logic                    stb_o,
   input  logic [WIDTH-1:0]        dat_i,
   input  logic                    ack_i,
   input  logic                    err_i
);

   localparam int unsigned SEL_W = WIDTH / 8;
   localparam int unsigned CNT_W = 16;

   // Reject unsupported configurations at elaboration time.
   if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
      $error("wb_master_port: WIDTH must be a non-zero multiple of 8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_master_port: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;

`ifdef WB_MASTER_PORT_TIMEOUT_EN
   // Counts completed BUS cycles; the abort fires in the cycle where the
   // count reaches TIMEOUT_CYCLES-1, so cyc_o stays up exactly TIMEOUT_CYCLES.
   logic [CNT_W-1:0] tmo_cnt;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`else
   assign rsp_timeout = 1'b0;
`endif

   // Single-process FSM; every output is a register updated here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         adr_o     <= '0;
         dat_o     <= '0;
         sel_o     <= '0;
         we_o      <= 1'b0;
         cyc_o     <= 1'b0;
         stb_o     <= 1'b0;
`ifdef WB_MASTER_PORT_TIMEOUT_EN
         rsp_timeout <= 1'b0;
         tmo_cnt     <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  adr_o     <= cmd_adr;
                  dat_o     <= cmd_dat;
                  sel_o     <= SEL_W'(cmd_sel);
                  we_o      <= cmd_we;
                  cyc_o     <= 1'b1;
                  stb_o     <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= BUS;
`ifdef WB_MASTER_PORT_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
               end
            end

            BUS: begin
               // err_i wins over ack_i; request drops on the capture edge.
               if (err_i) begin
                  rsp_err   <= 1'b1;
                  rsp_dat   <= '0;
                  rsp_valid <= 1'b1;
                  cyc_o     <= 1'b0;
                  stb_o     <= 1'b0;
                  state     <= RESP;
`ifdef WB_MASTER_PORT_TIMEOUT_EN
                  rsp_timeout <= 1'b0;
`endif
               end else if (ack_i) begin
                  rsp_err   <= 1'b0;
                  rsp_dat   <= we_o ? '0 : dat_i;
                  rsp_valid <= 1'b1;
                  cyc_o     <= 1'b0;
                  stb_o     <= 1'b0;
                  state     <= RESP;
`ifdef WB_MASTER_PORT_TIMEOUT_EN
                  rsp_timeout <= 1'b0;
               end else if (tmo_cnt == TMO_LAST) begin
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_dat     <= '0;
                  rsp_valid   <= 1'b1;
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  state       <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               rsp_valid <= 1'b0;
               cyc_o     <= 1'b0;
               stb_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_port.sv
// Testbench for wb_master_port with a behavioural 1024-word memory responder.
module tb_wb_master_port;

   localparam int unsigned W  = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TMO = 16;

   logic          clk, rst_i;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [W-1:0]  cmd_dat;
   logic [3:0]    cmd_sel;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
   logic [W-1:0]  rsp_dat;
   logic [AW-1:0] adr_o;
   logic [W-1:0]  dat_o, dat_i;
   logic [3:0]    sel_o;
   logic          we_o, cyc_o, stb_o, ack_i, err_i;

   int vectors = 0;
   int miscompares = 0;

   wb_master_port #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Responder: ack/err registered, gated by its own ack so each request is
   // answered once; resp_wait adds wait states; silent suppresses answers.
   logic [31:0] mem [1024];
   int  resp_wait = 0;
   int  wcnt = 0;
   bit  silent = 1'b0;

   always @(posedge clk) begin
      ack_i <= 1'b0;
      err_i <= 1'b0;
      if (cyc_o && stb_o && !ack_i && !err_i && !silent) begin
         if (wcnt < resp_wait) begin
            wcnt <= wcnt + 1;
         end else begin
            wcnt <= 0;
            if (adr_o >= 32'h1000) begin
               err_i <= 1'b1;
            end else begin
               ack_i <= 1'b1;
               if (we_o) begin
                  for (int b = 0; b < 4; b++)
                     if (sel_o[b]) mem[adr_o[11:2]][8*b +: 8] <= dat_o[8*b +: 8];
               end else begin
                  dat_i <= mem[adr_o[11:2]];
               end
            end
         end
      end else if (!stb_o) begin
         wcnt <= 0;
      end
   end

   // Reference model: sparse word memory, byte-merged writes, range check.
   logic [31:0] ref_mem [int unsigned];

   function automatic logic [31:0] ref_rd(input int unsigned idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction: handshake, wait for response, optional response
   // backpressure with cmd_valid held high, then consume.
   task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int wt, input int bp);
      logic [31:0] exp_dat, held;
      logic        exp_err, prev_ae;
      int unsigned idx;
      int          n;
      exp_err = (adr >= 32'h1000);
      idx     = adr / 4;
      exp_dat = 32'h0;
      if (!exp_err) begin
         if (we) begin
            logic [31:0] w;
            w = ref_rd(idx);
            for (int b = 0; b < 4; b++)
               if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
            ref_mem[idx] = w;
         end else begin
            exp_dat = ref_rd(idx);
         end
      end
      resp_wait = wt;
      @(negedge clk);
      check("cmd_ready_idle", {63'h0, cmd_ready}, 64'h1);
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      @(negedge clk);
      n = 1;
      if (bp == 0) cmd_valid = 1'b0;
      // Scramble the command inputs; the captured request must not follow.
      cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
      check("bus_req", {cyc_o, stb_o, we_o, sel_o, adr_o, dat_o},
            {1'b1, 1'b1, we, sel, adr, dat});
      while (!rsp_valid && n < 200) begin
         prev_ae = ack_i | err_i;
         @(negedge clk);
         n++;
         if (prev_ae) check("cyc_drop", {62'h0, cyc_o, stb_o}, 64'h0);
      end
      check("latency", 64'(n), 64'(3 + wt));
      check("rsp", {rsp_valid, rsp_err, rsp_timeout, busy, rsp_dat},
            {1'b1, exp_err, 1'b0, 1'b1, exp_dat});
      held = rsp_dat;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check("bp_hold", {rsp_valid, cmd_ready, cyc_o, rsp_dat},
               {1'b1, 1'b0, 1'b0, held});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("release", {61'h0, cmd_ready, rsp_valid, busy}, 64'h4);
      cmd_valid = 1'b0;
   endtask

   // Issue a command and leave the master waiting in BUS.
   task automatic start_cmd(input logic [31:0] adr);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = adr; cmd_dat = 32'h0; cmd_sel = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      ack_i = 1'b0; err_i = 1'b0; dat_i = 32'h0;
      rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
      cmd_sel = '0; rsp_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("reset_bus", {cyc_o, stb_o, we_o, sel_o, adr_o, dat_o}, 64'h0);
      check("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, busy, rsp_dat}, 64'h0);
      check("reset_cmd_ready", {63'h0, cmd_ready}, 64'h1);
      rst_i = 1'b0;

      // Directed sequence
      txn(1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 0);
      txn(1'b0, 32'h10,   32'h0,        4'hF, 0, 0);
      txn(1'b1, 32'h10,   32'h000000AA, 4'h1, 0, 0);
      txn(1'b0, 32'h10,   32'h0,        4'hF, 0, 0);
      txn(1'b0, 32'h1000, 32'h0,        4'hF, 0, 0);
      txn(1'b0, 32'h10,   32'h0,        4'hF, 1, 5);

      // Randomized traffic
      for (int k = 0; k < 30; k++) begin
         logic [31:0] a;
         if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
         else                           a = 32'($urandom_range(0, 15)) * 4;
         txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)));
      end

      // Unresponsive slave
      silent = 1'b1;
      start_cmd(32'h20);
`ifdef WB_MASTER_PORT_TIMEOUT_EN
      begin
         int hi;
         hi = 1;
         for (int i = 0; i < 100 && !rsp_valid; i++) begin
            @(negedge clk);
            if (cyc_o) hi++;
         end
         check("tmo_cyc_len", 64'(hi), 64'(TMO));
         check("tmo_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_dat},
               {1'b1, 1'b1, 1'b1, 32'h0});
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
      start_cmd(32'h24);
      repeat (3) @(negedge clk);
`else
      repeat (1000) @(negedge clk);
      check("no_tmo_wait", {61'h0, cyc_o, rsp_valid, busy}, 64'h5);
`endif

      // Asynchronous reset while in BUS
      check("pre_reset_bus", {62'h0, cyc_o, busy}, 64'h3);
      @(posedge clk);
      #2 rst_i = 1'b1;
      #1 check("async_reset", {61'h0, cyc_o, stb_o, busy}, 64'h0);
      @(negedge clk);
      rst_i = 1'b0;
      silent = 1'b0;
      @(negedge clk);
      check("post_reset", {61'h0, rsp_valid, cmd_ready, cyc_o}, 64'h2);

      txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
